// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS core: sequences ALU, unified memory port and
// register file over 3-5 cycles per instruction, stalls on mem_ready, counts retirements.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             MemWrite,
  output logic             IorD,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             Branch,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             ALUSrcA,
  output logic             zero_ext,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSrc,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_retired
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_LOGEX  = 4'd10,
    S_IMMWB  = 4'd11,
    S_JUMP   = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_e           state_q, state_d;
  logic             zext_q, zext_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = S_FETCH;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:                state_d = S_EXEC;
          OP_LW, OP_SW:            state_d = S_MEMADR;
          OP_BEQ:                  state_d = S_BRANCH;
          OP_ADDI:                 state_d = S_ADDIEX;
          OP_ANDI, OP_ORI, OP_XORI: state_d = S_LOGEX;
          OP_J:                    state_d = S_JUMP;
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_IMMWB;
      S_LOGEX:  state_d = S_IMMWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Moore decode; only the FETCH enables look at mem_ready, and reset masks every write enable.
  always_comb begin
    mem_read = 1'b0;
    MemWrite = 1'b0;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    Branch   = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcA  = 1'b0;
    zero_ext = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    PCSrc    = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        ALUSrcB  = 2'b01;
        IRWrite  = mem_ready;
        PCWrite  = mem_ready;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        IorD     = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 2'b01;
        Branch  = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_LOGEX: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = 2'b10;
        ALUOp    = 2'b11;
        zero_ext = 1'b1;
      end
      S_IMMWB: begin
        RegWrite = 1'b1;
        zero_ext = zext_q;
      end
      S_JUMP: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      Branch   = 1'b0;
    end
  end

  // The immediate-writeback state has no opcode decode of its own, so it replays the execute choice.
  always_comb begin
    zext_d = zext_q;
    if (state_q == S_LOGEX)  zext_d = 1'b1;
    if (state_q == S_ADDIEX) zext_d = 1'b0;
  end

  assign retire = (state_q == S_MEMWB) || (state_q == S_ALUWB) || (state_q == S_IMMWB) ||
                  (state_q == S_BRANCH) || (state_q == S_JUMP) ||
                  ((state_q == S_MEMWR) && mem_ready);
  assign cnt_d  = retire ? cnt_q + CNT_W'(1) : cnt_q;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      zext_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      zext_q  <= zext_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state         = state_q;
  assign instr_retired = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: an instruction-level trace model expands each
// instruction into its expected cycles; a negedge process compares every cycle.
module tb_multicycle_control;

  localparam int CNT_W = 32;

  logic             clk, reset, mem_ready;
  logic [5:0]       opcode;
  logic             mem_read, MemWrite, IorD, IRWrite, PCWrite, Branch, RegWrite;
  logic             RegDst, MemtoReg, ALUSrcA, zero_ext, illegal_op;
  logic [1:0]       ALUSrcB, ALUOp, PCSrc;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_retired;

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .mem_read(mem_read), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .Branch(Branch), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .zero_ext(zero_ext), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSrc(PCSrc), .state(state), .illegal_op(illegal_op),
    .instr_retired(instr_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, rdy, chk;
    logic [5:0]  op;
    logic [3:0]  st;
    logic        mem_read, mem_write, iord, irwrite, pcwrite, branch, regwrite;
    logic        regdst, memtoreg, alusrca, zext, illegal;
    logic [1:0]  alusrcb, aluop, pcsrc;
    logic [31:0] cnt;
  } cyc_t;

  typedef enum {K_R, K_LW, K_SW, K_BEQ, K_ADDI, K_LOGIC, K_J, K_BAD} kind_e;

  cyc_t        q[$];
  cyc_t        cur;
  logic        cur_valid = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc_no = 0;
  logic [31:0] model_cnt = 0;
  logic [5:0]  cur_op = 6'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic kind_e classify(input logic [5:0] op);
    case (op)
      6'b000000:                      return K_R;
      6'b100011:                      return K_LW;
      6'b101011:                      return K_SW;
      6'b000100:                      return K_BEQ;
      6'b001000:                      return K_ADDI;
      6'b001100, 6'b001101, 6'b001110: return K_LOGIC;
      6'b000010:                      return K_J;
      default:                        return K_BAD;
    endcase
  endfunction

  // A cycle in which nothing is asserted; mem_ready is irrelevant here, so it is scrambled.
  function automatic cyc_t blank(input logic [3:0] st);
    cyc_t r;
    r = '{default: '0};
    r.chk = 1'b1;
    r.rdy = 1'($urandom_range(0, 1));
    r.op  = cur_op;
    r.st  = st;
    r.cnt = model_cnt;
    return r;
  endfunction

  task automatic push_fetch(input int stalls);
    cyc_t r;
    r = blank(4'd0);
    r.mem_read = 1'b1;
    r.alusrcb  = 2'b01;
    r.rdy      = 1'b0;
    repeat (stalls) q.push_back(r);
    r.rdy = 1'b1;
    r.irwrite = 1'b1;
    r.pcwrite = 1'b1;
    q.push_back(r);
  endtask

  // Memory-access cycle: held with ready low for 'stalls' cycles, then completes.
  task automatic push_mem(input logic [3:0] st, input logic wr, input int stalls);
    cyc_t r;
    r = blank(st);
    r.iord      = 1'b1;
    r.mem_read  = ~wr;
    r.mem_write = wr;
    r.rdy       = 1'b0;
    repeat (stalls) q.push_back(r);
    r.rdy = 1'b1;
    q.push_back(r);
  endtask

  task automatic instr(input logic [5:0] op, input int fstall, input int mstall);
    cyc_t  r;
    kind_e k;
    cur_op = op;
    k = classify(op);
    push_fetch(fstall);
    r = blank(4'd1);
    r.alusrcb = 2'b11;
    r.illegal = (k == K_BAD);
    q.push_back(r);
    case (k)
      K_R: begin
        r = blank(4'd6); r.alusrca = 1'b1; r.aluop = 2'b10; q.push_back(r);
        r = blank(4'd7); r.regdst = 1'b1; r.regwrite = 1'b1; q.push_back(r);
      end
      K_LW, K_SW: begin
        r = blank(4'd2); r.alusrca = 1'b1; r.alusrcb = 2'b10; q.push_back(r);
        if (k == K_LW) begin
          push_mem(4'd3, 1'b0, mstall);
          r = blank(4'd4); r.memtoreg = 1'b1; r.regwrite = 1'b1; q.push_back(r);
        end else begin
          push_mem(4'd5, 1'b1, mstall);
        end
      end
      K_BEQ: begin
        r = blank(4'd8); r.alusrca = 1'b1; r.aluop = 2'b01; r.pcsrc = 2'b01; r.branch = 1'b1;
        q.push_back(r);
      end
      K_ADDI, K_LOGIC: begin
        r = blank(k == K_ADDI ? 4'd9 : 4'd10);
        r.alusrca = 1'b1; r.alusrcb = 2'b10;
        r.aluop = (k == K_ADDI) ? 2'b00 : 2'b11;
        r.zext  = (k == K_LOGIC);
        q.push_back(r);
        r = blank(4'd11); r.regwrite = 1'b1; r.zext = (k == K_LOGIC); q.push_back(r);
      end
      K_J: begin
        r = blank(4'd12); r.pcsrc = 2'b10; r.pcwrite = 1'b1; q.push_back(r);
      end
      default: ;
    endcase
    if (k != K_BAD) model_cnt = model_cnt + 1;
  endtask

  // sw stalled in MEMWR, then reset lands while the store is still pending.
  task automatic sw_abort();
    cyc_t r;
    cur_op = 6'b101011;
    push_fetch(0);
    r = blank(4'd1); r.alusrcb = 2'b11; q.push_back(r);
    r = blank(4'd2); r.alusrca = 1'b1; r.alusrcb = 2'b10; q.push_back(r);
    r = blank(4'd5); r.iord = 1'b1; r.mem_write = 1'b1; r.rdy = 1'b0; q.push_back(r);
    r.rst = 1'b1;
    r.mem_write = 1'b0;
    q.push_back(r);
    model_cnt = 0;
  endtask

  task automatic play();
    while (q.size() > 0) begin
      cur       = q.pop_front();
      reset     = cur.rst;
      mem_ready = cur.rdy;
      opcode    = cur.op;
      cur_valid = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (cur_valid && cur.chk) begin
      cyc_no++;
      check($sformatf("c%0d_state", cyc_no), 64'(state), 64'(cur.st));
      check($sformatf("c%0d_strobes", cyc_no),
            64'({mem_read, MemWrite, IorD, IRWrite, PCWrite, Branch, RegWrite}),
            64'({cur.mem_read, cur.mem_write, cur.iord, cur.irwrite, cur.pcwrite, cur.branch, cur.regwrite}));
      check($sformatf("c%0d_selects", cyc_no),
            64'({RegDst, MemtoReg, ALUSrcA, zero_ext, ALUSrcB, ALUOp, PCSrc}),
            64'({cur.regdst, cur.memtoreg, cur.alusrca, cur.zext, cur.alusrcb, cur.aluop, cur.pcsrc}));
      check($sformatf("c%0d_illegal", cyc_no), 64'(illegal_op), 64'(cur.illegal));
      check($sformatf("c%0d_retired", cyc_no), 64'(instr_retired), 64'(cur.cnt));
    end
  end

  initial begin
    cyc_t r;
    reset = 1'b1; mem_ready = 1'b1; opcode = 6'd0;
    // Reset for two cycles; the second one is checked with mem_ready high.
    r = blank(4'd0); r.chk = 1'b0; r.rst = 1'b1; r.rdy = 1'b1; q.push_back(r);
    r = blank(4'd0); r.rst = 1'b1; r.rdy = 1'b1; r.mem_read = 1'b1; r.alusrcb = 2'b01;
    q.push_back(r);
    play();

    instr(6'b000000, 0, 0);
    play();
    check("rtype_retired", 64'(instr_retired), 64'd1);
    check("rtype_back_to_fetch", 64'(state), 64'd0);

    instr(6'b100011, 0, 2);
    play();
    check("lw_retired", 64'(instr_retired), 64'd2);

    instr(6'b101011, 1, 2);
    instr(6'b001101, 0, 0);
    instr(6'b001000, 0, 0);
    instr(6'b001100, 0, 0);
    instr(6'b001110, 2, 0);
    play();
    check("imm_retired", 64'(instr_retired), 64'd7);

    instr(6'b111111, 0, 0);
    play();
    check("illegal_no_retire", 64'(instr_retired), 64'd7);

    instr(6'b000100, 0, 0);
    instr(6'b000010, 1, 0);
    instr(6'b100000, 0, 0);
    instr(6'b100011, 3, 1);
    play();
    check("mix_retired", 64'(instr_retired), 64'd10);

    sw_abort();
    play();
    check("abort_state", 64'(state), 64'd0);
    check("abort_memwrite", 64'(MemWrite), 64'd0);
    check("abort_retired", 64'(instr_retired), 64'd0);

    instr(6'b000000, 0, 0);
    play();
    check("post_reset_retired", 64'(instr_retired), 64'd1);

    cur_valid = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle MIPS core that runs the linear-search program. It sequences the shared ALU, the unified instruction/data memory port and the register file over 3–5 cycles per instruction. It drives `ALUOp` into the ALU-control decoder and all datapath mux selects and write enables. It also stalls on a memory ready handshake and counts retired instructions.

## Interface
- `CNT_W`, 32, width of the retired-instruction counter.
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `opcode`  in  6  IR[31:26], held stable by IR between IRWrite pulses.
- `mem_ready`  in  1  memory completes current read/write this cycle.
- `mem_read`, `MemWrite`  out  1  memory strobes; held until `mem_ready`.
- `IorD`  out  1  0 = PC address, 1 = ALUOut address.
- `IRWrite`, `PCWrite`, `Branch`, `RegWrite`  out  1  enables; `Branch` is ANDed with zero in the datapath.
- `RegDst`, `MemtoReg`, `ALUSrcA`, `zero_ext`  out  1  mux selects; `zero_ext` selects zero-extend of imm16.
- `ALUSrcB`  out  2  00 = B, 01 = 4, 10 = imm, 11 = imm<<2.
- `ALUOp`  out  2  00 add, 01 sub, 10 funct, 11 immediate-logical.
- `PCSrc`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- `state`  out  4  current state encoding, for debug.
- `illegal_op`  out  1  one-cycle pulse on an undecodable opcode.
- `instr_retired`  out  CNT_W  count of completed instructions.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, LOGEX 10, IMMWB 11, JUMP 12. Encodings 13–15 go to FETCH.
- Outputs are Moore-decoded from `state`, except that `IRWrite`/`PCWrite` in FETCH are qualified by `mem_ready`. Every output not listed for a state is 0.
- FETCH:
  - Outputs: mem_read=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, IRWrite=PCWrite=mem_ready.
  - Next state: DECODE if mem_ready, else stay.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode:
  - 000000 → EXEC
  - 100011 or 101011 → MEMADR
  - 000100 → BRANCH
  - 001000 → ADDIEX
  - 001100/001101/001110 → LOGEX
  - 000010 → JUMP
  - other → FETCH with `illegal_op`=1 that cycle
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state: MEMRD if lw, MEMWR if sw.
- MEMRD: mem_read=1, IorD=1. Next state: MEMWB on mem_ready, else stay.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Next state: FETCH.
- MEMWR: MemWrite=1, IorD=1. Next state: FETCH on mem_ready, else stay.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state: ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Next state: FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1. Next state: FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00, zero_ext=0. Next state: IMMWB.
- LOGEX: ALUSrcA=1, ALUSrcB=10, ALUOp=11, zero_ext=1. Next state: IMMWB.
- IMMWB: RegDst=0, MemtoReg=0, RegWrite=1, and `zero_ext` is held at its LOGEX/ADDIEX value via a registered flag. Next state: FETCH.
- JUMP: PCSrc=10, PCWrite=1. Next state: FETCH.
- `instr_retired` increments by 1 on the transition into FETCH from MEMWB, MEMWR, ALUWB, IMMWB, BRANCH or JUMP.
  - Not incremented on the illegal-opcode path.
  - Wraps modulo 2^CNT_W.

## Timing
- Reset:
  - Effective at the clock edge while `reset`=1: state=FETCH, instr_retired=0, zero_ext flag=0.
  - Outputs then show FETCH decode; no write enable asserts while `reset`=1 regardless of `mem_ready`.
  - Reset mid-instruction (any state) aborts it with no further RegWrite/MemWrite.
- Cycles per instruction with `mem_ready` tied 1:
  - beq/j: 3
  - R-type/addi/logical/sw: 4
  - lw: 5
- Each cycle of `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle. Strobes and address select stay constant during the stall.
- PCWrite and IRWrite pulse for exactly one cycle per fetch, in the cycle `mem_ready`=1.
- `illegal_op` is combinational from state=DECODE and opcode, and lasts exactly one cycle.

## Test plan
- Reset then `mem_ready`=1, opcode=000000: state sequence 0,1,6,7,0. ALUOp=10 in EXEC. RegWrite=1 and RegDst=1 only in ALUWB. instr_retired=1.
- lw (100011) with `mem_ready` low for 2 cycles in MEMRD: sequence 0,1,2,3,3,3,4,0. mem_read and IorD=1 are held across the stall. MemtoReg=1 in MEMWB.
- sw (101011) with `mem_ready`=0 for 1 cycle in FETCH: IRWrite/PCWrite stay 0 during the stall and pulse once. MemWrite is held in MEMWR until ready. No RegWrite at any point.
- ori (001101): LOGEX shows ALUOp=11 and zero_ext=1. IMMWB shows RegWrite=1, RegDst=0, zero_ext=1. For addi (001000), zero_ext=0 throughout.
- opcode 111111: state 0→1→0, illegal_op pulses once, instr_retired is unchanged. Then beq (000100) gives BRANCH with ALUOp=01, PCSrc=01, Branch=1.
- Assert `reset` during MEMWR with `mem_ready`=0: the next state is FETCH, MemWrite deasserts, and instr_retired=0.
